// File: rtl/bcrypt_hash_cmp.sv
// bcrypt_hash_cmp: hash-table comparator stage behind the comparator-config parser.
//
// The parser writes 32-bit partial hashes into a word-wide table one byte at a time.
// Each entry is little-endian. After a new list is committed, every cmp_start runs a
// linear search over the active entries and reports the lowest matching index.
//
// Ports:
//   CLK                 single clock, posedge
//   rst                 synchronous active-high reset
//   hash_count          number of valid entries, latched when a new list is applied
//   cmp_wr_addr         byte address: [HASH_NUM_MSB+2:2] entry, [1:0] lane
//   cmp_wr_en/cmp_din   byte write strobe / data
//   new_cmp_config      parser finished writing a list (level)
//   cmp_config_applied  one-cycle pulse: list committed, active count updated
//   cmp_data/cmp_start  hash to search for / search request
//   cmp_busy            search running or apply pending (combinational)
//   cmp_done            one-cycle pulse: result valid
//   cmp_found           match flag, held until next cmp_done
//   cmp_hash_num        lowest matching index
//   err_wr_busy         sticky: a byte write arrived during a search
module bcrypt_hash_cmp #(
    parameter int unsigned HASH_NUM_MSB   = 9,
    parameter int unsigned HASH_COUNT_MSB = 10
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [HASH_COUNT_MSB:0]   hash_count,
    input  logic [HASH_NUM_MSB+2:0]   cmp_wr_addr,
    input  logic                      cmp_wr_en,
    input  logic [7:0]                cmp_din,
    input  logic                      new_cmp_config,
    output logic                      cmp_config_applied,
    input  logic [31:0]               cmp_data,
    input  logic                      cmp_start,
    output logic                      cmp_busy,
    output logic                      cmp_done,
    output logic                      cmp_found,
    output logic [HASH_NUM_MSB:0]     cmp_hash_num,
    output logic                      err_wr_busy
);

    localparam int unsigned NUM_W = HASH_NUM_MSB + 1;
    localparam int unsigned IDX_W = HASH_NUM_MSB + 2;
    localparam int unsigned CNT_W = HASH_COUNT_MSB + 1;
    localparam int unsigned DEPTH = 2 ** NUM_W;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    state_t              r_state;
    logic [23:0]         r_hold;
    logic [CNT_W-1:0]    r_active_cnt;
    logic [31:0]         r_target;
    logic [IDX_W-1:0]    r_rd_addr;
    logic [IDX_W-1:0]    r_rd_idx;
    logic                r_rd_valid;
    logic [31:0]         r_rdata;
    logic                r_applied;
    logic                r_apply_lock;
    logic                r_done;
    logic                r_found;
    logic [NUM_W-1:0]    r_hash_num;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH];

    logic [NUM_W-1:0]    w_wr_entry;
    logic [1:0]          w_wr_lane;
    logic                w_word_wr;
    logic                w_busy;
    logic                w_apply;
    logic                w_last_idx;

    assign w_wr_entry = cmp_wr_addr[HASH_NUM_MSB+2:2];
    assign w_wr_lane  = cmp_wr_addr[1:0];
    assign w_word_wr  = cmp_wr_en && (w_wr_lane == 2'd3);

    // Busy also covers a pending apply so the parser's commit beats a same-cycle start.
    assign w_busy = (r_state != ST_IDLE) || (new_cmp_config && !r_applied);

    // The lock keeps a held new_cmp_config from producing a second pulse.
    assign w_apply = (r_state == ST_IDLE) && new_cmp_config && !r_applied && !r_apply_lock;

    // Word in r_rdata is the last active entry.
    assign w_last_idx = (CNT_W'(r_rd_idx) == (r_active_cnt - CNT_W'(1)));

    // Table RAM: one write port, one synchronous read port, no reset.
    always_ff @(posedge CLK) begin : p_ram
        if (w_word_wr) begin
            r_mem[w_wr_entry] <= {cmp_din, r_hold};
        end
        r_rdata <= r_mem[r_rd_addr[NUM_W-1:0]];
    end

    // Byte holding register, handshake, search FSM and status outputs.
    always_ff @(posedge CLK) begin : p_ctrl
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= 24'd0;
            r_active_cnt <= '0;
            r_target     <= 32'd0;
            r_rd_addr    <= '0;
            r_rd_idx     <= '0;
            r_rd_valid   <= 1'b0;
            r_applied    <= 1'b0;
            r_apply_lock <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_hash_num   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_applied <= 1'b0;

            if (cmp_wr_en) begin
                case (w_wr_lane)
                    2'd0:    r_hold[7:0]   <= cmp_din;
                    2'd1:    r_hold[15:8]  <= cmp_din;
                    2'd2:    r_hold[23:16] <= cmp_din;
                    default: ;
                endcase
            end

            if (cmp_wr_en && (r_state == ST_SEARCH)) begin
                r_err <= 1'b1;
            end

            if (!new_cmp_config) begin
                r_apply_lock <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_apply) begin
                        r_applied    <= 1'b1;
                        r_apply_lock <= 1'b1;
                        r_active_cnt <= hash_count;
                    end else if (cmp_start && !w_busy) begin
                        r_target   <= cmp_data;
                        r_rd_addr  <= '0;
                        r_rd_valid <= 1'b0;
                        if (r_active_cnt == '0) begin
                            r_done  <= 1'b1;
                            r_found <= 1'b0;
                        end else begin
                            r_state <= ST_SEARCH;
                        end
                    end
                end

                ST_SEARCH: begin
                    // Read issue runs one cycle ahead of the compare.
                    r_rd_addr  <= r_rd_addr + IDX_W'(1);
                    r_rd_idx   <= r_rd_addr;
                    r_rd_valid <= 1'b1;
                    if (r_rd_valid && (r_rdata == r_target)) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_found    <= 1'b1;
                        r_hash_num <= r_rd_idx[NUM_W-1:0];
                        r_rd_valid <= 1'b0;
                    end else if (r_rd_valid && w_last_idx) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_found    <= 1'b0;
                        r_rd_valid <= 1'b0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmp_config_applied = r_applied;
    assign cmp_busy           = w_busy;
    assign cmp_done           = r_done;
    assign cmp_found          = r_found;
    assign cmp_hash_num       = r_hash_num;
    assign err_wr_busy        = r_err;

endmodule

// File: tb/tb_bcrypt_hash_cmp.sv
// Bench for bcrypt_hash_cmp: byte-level table model, search reference and handshake scenarios.
module tb_bcrypt_hash_cmp;

    logic        CLK;
    logic        rst;
    logic [10:0] hash_count;
    logic [11:0] cmp_wr_addr;
    logic        cmp_wr_en;
    logic [7:0]  cmp_din;
    logic        new_cmp_config;
    logic        cmp_config_applied;
    logic [31:0] cmp_data;
    logic        cmp_start;
    logic        cmp_busy;
    logic        cmp_done;
    logic        cmp_found;
    logic [9:0]  cmp_hash_num;
    logic        err_wr_busy;

    int checks;
    int errors;

    // Reference state: table contents, the three pending bytes and the active count.
    logic [31:0] m_mem [1024];
    logic [7:0]  m_hold [3];
    int          m_cnt;

    bcrypt_hash_cmp #(.HASH_NUM_MSB(9), .HASH_COUNT_MSB(10)) dut (
        .CLK                (CLK),
        .rst                (rst),
        .hash_count         (hash_count),
        .cmp_wr_addr        (cmp_wr_addr),
        .cmp_wr_en          (cmp_wr_en),
        .cmp_din            (cmp_din),
        .new_cmp_config     (new_cmp_config),
        .cmp_config_applied (cmp_config_applied),
        .cmp_data           (cmp_data),
        .cmp_start          (cmp_start),
        .cmp_busy           (cmp_busy),
        .cmp_done           (cmp_done),
        .cmp_found          (cmp_found),
        .cmp_hash_num       (cmp_hash_num),
        .err_wr_busy        (err_wr_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_byte(input int unsigned entry, input int unsigned lane, input logic [7:0] b);
        cmp_wr_addr = 12'(entry * 4 + lane);
        cmp_din     = b;
        cmp_wr_en   = 1'b1;
        tick();
        cmp_wr_en   = 1'b0;
        if (lane < 3) m_hold[lane] = b;
        else m_mem[entry] = {b, m_hold[2], m_hold[1], m_hold[0]};
    endtask

    task automatic write_word(input int unsigned entry, input logic [31:0] v);
        for (int l = 0; l < 4; l++) wr_byte(entry, l, v[8*l +: 8]);
    endtask

    // Spec-level answer: lowest matching index, and the cycle its done appears.
    task automatic ref_search(input logic [31:0] v, output logic f, output int idx, output int lat);
        f = 1'b0; idx = 0;
        lat = (m_cnt == 0) ? 1 : m_cnt + 2;
        for (int i = 0; i < m_cnt; i++) begin
            if (!f && m_mem[i] == v) begin
                f = 1'b1; idx = i; lat = i + 3;
            end
        end
    endtask

    // Drives one search and reports what the DUT did; lat = -1 on timeout.
    task automatic run_search(input logic [31:0] v, output int lat, output logic f, output logic [9:0] num);
        lat = -1; f = 1'b0; num = '0;
        cmp_data  = v;
        cmp_start = 1'b1;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            if (k == 1) cmp_start = 1'b0;
            if (cmp_done) begin
                lat = k; f = cmp_found; num = cmp_hash_num;
                break;
            end
        end
        tick();
    endtask

    task automatic apply_cfg(input int cnt);
        bit got;
        got = 1'b0;
        hash_count     = 11'(cnt);
        new_cmp_config = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cmp_config_applied) begin
                got = 1'b1;
                break;
            end
        end
        new_cmp_config = 1'b0;
        tick();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL apply_cfg(%0d) applied pulse got none want one", cnt);
        end
        m_cnt = cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({cmp_config_applied, cmp_busy, cmp_done, cmp_found, err_wr_busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {cmp_config_applied, cmp_busy, cmp_done, cmp_found, err_wr_busy});
        end
        checks++;
        if (cmp_hash_num !== 10'd0) begin
            errors++;
            $display("FAIL reset_hash_num got %0d want 0", cmp_hash_num);
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [4];
        logic ef, gf;
        int ei, el, gl;
        logic [9:0] gn;
        vals[0] = 32'hCAFEBABE; vals[1] = 32'h12345678;
        vals[2] = 32'h11223344; vals[3] = 32'h00000000;
        write_word(0, 32'h11223344);
        write_word(1, 32'hDEADBEEF);
        write_word(2, 32'h00000000);
        write_word(3, 32'hCAFEBABE);
        apply_cfg(4);
        for (int t = 0; t < 5; t++) begin
            logic [31:0] v;
            if (t == 4) begin
                write_word(3, 32'hDEADBEEF);
                apply_cfg(4);
                v = 32'hDEADBEEF;
            end else begin
                v = vals[t];
            end
            ref_search(v, ef, ei, el);
            run_search(v, gl, gf, gn);
            checks++;
            if (gl !== el) begin
                errors++;
                $display("FAIL basic[%0d] latency got %0d want %0d", t, gl, el);
            end
            checks++;
            if (gf !== ef) begin
                errors++;
                $display("FAIL basic[%0d] found got %0b want %0b", t, gf, ef);
            end
            if (ef) begin
                checks++;
                if (gn !== 10'(ei)) begin
                    errors++;
                    $display("FAIL basic[%0d] hash_num got %0d want %0d", t, gn, ei);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        int gl;
        logic gf;
        logic [9:0] gn;
        apply_cfg(0);
        run_search(32'h11223344, gl, gf, gn);
        checks++;
        if (gl !== 1) begin
            errors++;
            $display("FAIL zero_count latency got %0d want 1", gl);
        end
        checks++;
        if (gf !== 1'b0) begin
            errors++;
            $display("FAIL zero_count found got %0b want 0", gf);
        end
    endtask

    task automatic test_handshake();
        int pulses, done_k, app_k, dones;
        logic ef;
        int ei, el;
        // Held level gives a single pulse.
        hash_count     = 11'd4;
        new_cmp_config = 1'b1;
        pulses = 0;
        repeat (5) begin
            tick();
            if (cmp_config_applied) pulses++;
        end
        new_cmp_config = 1'b0;
        tick();
        m_cnt = 4;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_new pulses got %0d want 1", pulses);
        end
        // New list raised mid-search is only committed after the result.
        ref_search(32'h12345678, ef, ei, el);
        cmp_data  = 32'h12345678;
        cmp_start = 1'b1;
        done_k = -1; app_k = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                cmp_start      = 1'b0;
                new_cmp_config = 1'b1;
            end
            if (cmp_done && done_k < 0) done_k = k;
            if (cmp_config_applied && app_k < 0) app_k = k;
        end
        new_cmp_config = 1'b0;
        tick();
        checks++;
        if (done_k !== el) begin
            errors++;
            $display("FAIL apply_in_search done cycle got %0d want %0d", done_k, el);
        end
        checks++;
        if (!(app_k > done_k && done_k > 0)) begin
            errors++;
            $display("FAIL apply_in_search applied cycle got %0d want after %0d", app_k, done_k);
        end
        // Start coincident with a pending apply is dropped.
        cmp_data       = 32'h11223344;
        cmp_start      = 1'b1;
        new_cmp_config = 1'b1;
        tick();
        cmp_start = 1'b0;
        checks++;
        if (cmp_config_applied !== 1'b1) begin
            errors++;
            $display("FAIL start_vs_apply applied got %0b want 1", cmp_config_applied);
        end
        tick();
        new_cmp_config = 1'b0;
        dones = 0;
        repeat (10) begin
            tick();
            if (cmp_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL start_vs_apply done pulses got %0d want 0", dones);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        int cnt;
        logic ef, gf;
        int ei, el, gl;
        logic [9:0] gn;
        for (int p = 0; p < 6; p++) pool[p] = $urandom;
        cnt = $urandom_range(1, 16);
        for (int e = 0; e < cnt; e++) begin
            logic [31:0] v;
            v = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) begin
                wr_byte(e, 3, v[31:24]);
            end else if ($urandom_range(0, 1) == 0) begin
                write_word(e, v);
            end else begin
                wr_byte(e, 2, v[23:16]);
                wr_byte(e, 0, v[7:0]);
                wr_byte(e, 1, v[15:8]);
                wr_byte(e, 3, v[31:24]);
            end
        end
        apply_cfg(cnt);
        for (int t = 0; t < 12; t++) begin
            logic [31:0] v;
            v = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 5)] : 32'($urandom);
            ref_search(v, ef, ei, el);
            run_search(v, gl, gf, gn);
            checks++;
            if (gl !== el || gf !== ef || (ef && gn !== 10'(ei))) begin
                errors++;
                $display("FAIL random[%0d] v=%h got lat %0d found %0b idx %0d want lat %0d found %0b idx %0d",
                         t, v, gl, gf, gn, el, ef, ei);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] vals [2];
        logic ef, gf;
        int ei, el, gl;
        logic [9:0] gn;
        for (int e = 0; e < 1024; e++) write_word(e, 32'h9E3779B1 * 32'(e) + 32'h01234567);
        apply_cfg(1024);
        vals[0] = 32'h9E3779B1 * 32'd1023 + 32'h01234567;
        vals[1] = 32'h9E3779B1 * 32'd2000 + 32'h01234567;
        for (int t = 0; t < 2; t++) begin
            ref_search(vals[t], ef, ei, el);
            run_search(vals[t], gl, gf, gn);
            checks++;
            if (gl !== el) begin
                errors++;
                $display("FAIL full[%0d] latency got %0d want %0d", t, gl, el);
            end
            checks++;
            if (gf !== ef || (ef && gn !== 10'(ei))) begin
                errors++;
                $display("FAIL full[%0d] found/idx got %0b/%0d want %0b/%0d", t, gf, gn, ef, ei);
            end
        end
    endtask

    task automatic test_wr_busy_and_reset();
        int dones;
        cmp_data  = 32'hFFFF0000;
        cmp_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) cmp_start = 1'b0;
            if (k == 3) begin
                cmp_wr_addr = 12'd0;
                cmp_din     = 8'h5A;
                cmp_wr_en   = 1'b1;
            end
            if (k == 4) cmp_wr_en = 1'b0;
        end
        checks++;
        if (err_wr_busy !== 1'b1) begin
            errors++;
            $display("FAIL err_wr_busy got %0b want 1", err_wr_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cnt = 0;
        for (int l = 0; l < 3; l++) m_hold[l] = 8'h00;
        checks++;
        if ({cmp_config_applied, cmp_busy, cmp_done, cmp_found, err_wr_busy} !== 5'b0 ||
            cmp_hash_num !== 10'd0) begin
            errors++;
            $display("FAIL mid_search_reset outputs got %b/%0d want 00000/0",
                     {cmp_config_applied, cmp_busy, cmp_done, cmp_found, err_wr_busy}, cmp_hash_num);
        end
        dones = 0;
        repeat (1100) begin
            tick();
            if (cmp_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL mid_search_reset done pulses got %0d want 0", dones);
        end
    endtask

    initial begin
        checks = 0; errors = 0; m_cnt = 0;
        for (int l = 0; l < 3; l++) m_hold[l] = 8'h00;
        for (int e = 0; e < 1024; e++) m_mem[e] = 32'h0;
        rst = 1'b1; hash_count = '0; cmp_wr_addr = '0; cmp_wr_en = 1'b0; cmp_din = '0;
        new_cmp_config = 1'b0; cmp_data = '0; cmp_start = 1'b0;
        test_reset();
        test_basic();
        test_zero_count();
        test_handshake();
        test_random();
        test_full();
        test_wr_busy_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
